// File: rtl/park_timer_pkg.sv
// park_timer_pkg: shared FSM state type and prescaler sizing helpers for park_timer_sched
package park_timer_pkg;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
  function automatic int calc_div(int clk_hz, int tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int calc_pw(int clk_hz, int tick_hz);
    return calc_div(clk_hz, tick_hz) > 1 ? $clog2(calc_div(clk_hz, tick_hz)) : 1;
  endfunction
endpackage

// File: rtl/park_timer_sched_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick enable every CLK_HZ/TICK_HZ cycles
// Ports: clk_50MHz, reset (async, active-high), hold (freeze count, suppress tick), tick (one-cycle pulse)
module tick_prescaler
  import park_timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW = calc_pw(CLK_HZ, TICK_HZ);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  logic [PW-1:0] cnt;
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) cnt <= '0;
    else if (!hold) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
  assign tick = cnt == LAST && !hold;
endmodule

// File: rtl/park_timer_sched.sv
// park_timer_sched: NCH second-resolution countdown timers sharing one decrement unit walked by a scan FSM
// Ports: clk_50MHz, reset (async, active-high), start/cancel (per-channel strobes), load_val (NCH x CNT_W seconds),
//        busy (channel counting), done (one-cycle expiry), tick (1 Hz enable), rd_sel/rd_val (registered readback)
// Option: define TIMER_PAUSE_EN to add input pause, which freezes the prescaler and blocks new scans.
module park_timer_sched
  import park_timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int NCH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk_50MHz,
  input  logic                     reset,
`ifdef TIMER_PAUSE_EN
  input  logic                     pause,
`endif
  input  logic [NCH-1:0]           start,
  input  logic [NCH-1:0]           cancel,
  input  logic [NCH*CNT_W-1:0]     load_val,
  output logic [NCH-1:0]           busy,
  output logic [NCH-1:0]           done,
  output logic                     tick,
  input  logic [$clog2(NCH)-1:0]   rd_sel,
  output logic [CNT_W-1:0]         rd_val
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int IW = $clog2(NCH);
  localparam logic [IW-1:0] LAST_CH = IW'(NCH - 1);
  // The scan must finish well before the next tick arrives.
  if (DIV <= NCH + 2) begin : g_bad_div
    $error("park_timer_sched: CLK_HZ/TICK_HZ must exceed NCH+2");
  end
  logic hold;
`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_pre (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .hold(hold),
    .tick(tick)
  );
  state_t state;
  logic [IW-1:0] idx;
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
    end else if (state == IDLE) begin
      state <= tick ? SCAN : IDLE;
      idx <= '0;
    end else begin
      state <= idx == LAST_CH ? IDLE : SCAN;
      idx <= idx == LAST_CH ? '0 : idx + 1'b1;
    end
  logic [CNT_W-1:0] cnt [NCH];
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] ld, n;
    logic hit, b, d;
    assign ld = load_val[c*CNT_W +: CNT_W];
    assign hit = state == SCAN && idx == IW'(c) && b;
    // Priority: cancel over start over the scan decrement.
    always_ff @(posedge clk_50MHz or posedge reset)
      if (reset) begin
        n <= '0;
        b <= 1'b0;
        d <= 1'b0;
      end else if (cancel[c]) begin
        n <= '0;
        b <= 1'b0;
        d <= 1'b0;
      end else if (start[c]) begin
        n <= ld;
        b <= ld != '0;
        d <= ld == '0;
      end else if (hit) begin
        n <= n - 1'b1;
        b <= n != CNT_W'(1);
        d <= n == CNT_W'(1);
      end else begin
        d <= 1'b0;
      end
    assign cnt[c] = n;
    assign busy[c] = b;
    assign done[c] = d;
  end
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) rd_val <= '0;
    else rd_val <= cnt[rd_sel];
endmodule

// File: tb/tb_park_timer_sched.sv
// tb_park_timer_sched: table-driven and scoreboard checks of park_timer_sched with DIV=10, NCH=4, CNT_W=8
module tb_park_timer_sched;
  logic clk_50MHz = 0, reset = 0, pause = 0;
  logic [3:0] start = 0, cancel = 0;
  logic [31:0] load_val = 0;
  logic [1:0] rd_sel = 0;
  logic [3:0] busy, done;
  logic tick;
  logic [7:0] rd_val;
  int cyc = 0, ep = 0, t0 = 0, t1 = 0, checks = 0, errors = 0;
  bit hit;
  typedef struct {int ch; int at;} ev_t;
  ev_t exp_q[$];
  typedef struct {
    int s; logic [3:0] st; logic [3:0] cn; logic [31:0] ld; logic [1:0] sel;
    logic [3:0] bz; int rd; logic [3:0] dm; int db;
  } vec_t;
  vec_t tbl [8];
  park_timer_sched #(.CLK_HZ(10), .TICK_HZ(1), .NCH(4), .CNT_W(8)) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .start(start),
    .cancel(cancel),
    .load_val(load_val),
    .busy(busy),
    .done(done),
    .tick(tick),
    .rd_sel(rd_sel),
    .rd_val(rd_val)
  );
  always #5 clk_50MHz = ~clk_50MHz;
  always @(posedge clk_50MHz) cyc <= cyc + 1;
  always @(posedge clk_50MHz or posedge reset)
    if (reset) ep <= 0;
    else if (!pause) ep <= ep == 9 ? 0 : ep + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask
  task automatic do_reset(int n);
    reset = 1;
    start = 0;
    cancel = 0;
    repeat (n) @(posedge clk_50MHz);
    #1 reset = 0;
  endtask
  always @(negedge clk_50MHz) begin
    chk("tick", int'(tick), int'(!reset && ep == 9 && !pause));
    for (int c = 0; c < 4; c++) begin
      hit = 0;
      for (int k = exp_q.size() - 1; k >= 0; k--)
        if (exp_q[k].ch == c && exp_q[k].at == cyc) begin
          hit = 1;
          exp_q.delete(k);
        end
      chk($sformatf("done[%0d]", c), int'(done[c]), int'(hit));
    end
  end
  initial begin
    tbl[0] = '{5,  4'b0100, 4'b0000, 32'h0003_0000, 2'd2, 4'b0100, 3, 4'b0100, 31};
    tbl[1] = '{7,  4'b0001, 4'b0000, 32'h0000_0000, 2'd0, 4'b0100, 0, 4'b0001, 8};
    tbl[2] = '{15, 4'b0010, 4'b0000, 32'h0000_0500, 2'd1, 4'b0110, 5, 4'b0000, 0};
    tbl[3] = '{35, 4'b0010, 4'b0000, 32'h0000_0200, 2'd1, 4'b0010, 2, 4'b0000, 0};
    tbl[4] = '{45, 4'b1000, 4'b1000, 32'h0700_0000, 2'd3, 4'b0010, 0, 4'b0000, 0};
    tbl[5] = '{51, 4'b0010, 4'b0000, 32'h0000_0400, 2'd1, 4'b0010, 4, 4'b0000, 0};
    tbl[6] = '{71, 4'b0000, 4'b0010, 32'h0000_0000, 2'd1, 4'b0000, 0, 4'b0000, 0};
    tbl[7] = '{85, 4'b1111, 4'b0000, 32'h0101_0101, 2'd3, 4'b1111, 1, 4'b1111, 91};
    do_reset(3);
    t0 = cyc;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset rd_val", int'(rd_val), 0);
    for (int i = 0; i < 8; i++) begin
      wait_until(t0 + tbl[i].s);
      start = tbl[i].st;
      cancel = tbl[i].cn;
      load_val = tbl[i].ld;
      rd_sel = tbl[i].sel;
      for (int c = 0; c < 4; c++)
        if (tbl[i].dm[c]) exp_q.push_back('{c, t0 + tbl[i].db + c});
      wait_until(t0 + tbl[i].s + 1);
      start = 0;
      cancel = 0;
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].bz));
      wait_until(t0 + tbl[i].s + 2);
      chk($sformatf("vec%0d rd_val", i), int'(rd_val), tbl[i].rd);
    end
    wait_until(t0 + 105);
    start = 4'b1111;
    load_val = 32'h0101_0101;
    exp_q.push_back('{0, t0 + 111});
    wait_until(t0 + 106);
    start = 0;
    wait_until(t0 + 111);
    chk("conc busy", int'(busy), int'(4'b1110));
    wait_until(t0 + 112);
    do_reset(3);
    t1 = cyc;
    chk("rst2 busy", int'(busy), 0);
    chk("rst2 done", int'(done), 0);
    chk("rst2 tick", int'(tick), 0);
    chk("rst2 rd_val", int'(rd_val), 0);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      wait_until(cyc + 1);
      chk($sformatf("rst2 cnt[%0d]", s), int'(rd_val), 0);
    end
    wait_until(t1 + 5);
    start = 4'b0100;
    load_val = 32'h0003_0000;
    rd_sel = 2;
    exp_q.push_back('{2, t1 + 33});
    wait_until(t1 + 6);
    start = 0;
    wait_until(t1 + 7);
    chk("rd load", int'(rd_val), 3);
    wait_until(t1 + 13);
    chk("rd before scan", int'(rd_val), 3);
    wait_until(t1 + 14);
    chk("rd tick1", int'(rd_val), 2);
    wait_until(t1 + 24);
    chk("rd tick2", int'(rd_val), 1);
    wait_until(t1 + 32);
    chk("busy2 before expiry", int'(busy[2]), 1);
    wait_until(t1 + 33);
    chk("busy2 at expiry", int'(busy[2]), 0);
    wait_until(t1 + 34);
    chk("rd tick3", int'(rd_val), 0);
    wait_until(t1 + 45);
    start = 4'b0001;
    load_val = 32'h0000_0002;
`ifdef TIMER_PAUSE_EN
    exp_q.push_back('{0, t1 + 86});
`else
    exp_q.push_back('{0, t1 + 61});
`endif
    wait_until(t1 + 46);
    start = 0;
`ifdef TIMER_PAUSE_EN
    wait_until(t1 + 52);
    pause = 1;
    wait_until(t1 + 77);
    pause = 0;
`endif
    wait_until(t1 + 100);
    chk("pending done events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
